// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: shares one external SRAM between SNES bus cycles (priority)
// and MCU byte requests, with fixed read/write strobe timing.
module sram_access_ctrl #(
   parameter int RD_WAIT = 3,
   parameter int WR_WAIT = 3
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        SNES_RD_n,
   input  logic        SNES_WR_n,
   input  logic [23:0] ROM_ADDR,
   input  logic        IS_ROM,
   input  logic        IS_SAVERAM,
   input  logic [7:0]  SNES_DATA_IN,
   output logic [7:0]  SNES_DATA_OUT,
   output logic        SNES_DATA_VALID,
   input  logic        MCU_REQ,
   input  logic        MCU_WE,
   input  logic [23:0] MCU_ADDR,
   input  logic [7:0]  MCU_WDATA,
   output logic [7:0]  MCU_RDATA,
   output logic        MCU_ACK,
   output logic [23:0] SRAM_ADDR,
   input  logic [7:0]  SRAM_DQ_IN,
   output logic [7:0]  SRAM_DQ_OUT,
   output logic        SRAM_DQ_OE,
   output logic        SRAM_CE_n,
   output logic        SRAM_OE_n,
   output logic        SRAM_WE_n
);
   typedef enum logic [1:0] {IDLE, RD, WR, RECOVER} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        src_q, src_d;
   logic        rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
   logic        rd_prev_q, wr_prev_q;
   logic [23:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d, addr_q, addr_d;
   logic [7:0]  wr_data_q, wr_data_d, dq_out_q, dq_out_d, snes_do_q, snes_do_d, mcu_rd_q, mcu_rd_d;
   logic        dq_oe_q, dq_oe_d, ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
   logic        valid_q, valid_d, ack_q, ack_d;
   logic        rd_ev, wr_ev;

   assign rd_ev = rd_prev_q & ~SNES_RD_n & (IS_ROM | IS_SAVERAM);
   assign wr_ev = ~wr_prev_q & SNES_WR_n & IS_SAVERAM;

   // src_q: 1 = MCU owns the running cycle, 0 = SNES
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      src_d     = src_q;
      rd_pend_d = rd_pend_q | rd_ev;
      wr_pend_d = wr_pend_q | wr_ev;
      rd_addr_d = rd_ev ? ROM_ADDR : rd_addr_q;
      wr_addr_d = wr_ev ? ROM_ADDR : wr_addr_q;
      wr_data_d = wr_ev ? SNES_DATA_IN : wr_data_q;
      addr_d    = addr_q;
      dq_out_d  = dq_out_q;
      dq_oe_d   = dq_oe_q;
      ce_n_d    = ce_n_q;
      oe_n_d    = oe_n_q;
      we_n_d    = we_n_q;
      snes_do_d = snes_do_q;
      mcu_rd_d  = mcu_rd_q;
      valid_d   = 1'b0;
      ack_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_pend_d) begin
               state_d   = RD;
               addr_d    = rd_addr_d;
               cnt_d     = 4'(RD_WAIT);
               src_d     = 1'b0;
               rd_pend_d = 1'b0;
               ce_n_d    = 1'b0;
               oe_n_d    = 1'b0;
            end else if (wr_pend_d) begin
               state_d   = WR;
               addr_d    = wr_addr_d;
               dq_out_d  = wr_data_d;
               cnt_d     = 4'(WR_WAIT);
               src_d     = 1'b0;
               wr_pend_d = 1'b0;
               ce_n_d    = 1'b0;
               we_n_d    = 1'b0;
               dq_oe_d   = 1'b1;
            end else if (MCU_REQ) begin
               state_d  = MCU_WE ? WR : RD;
               addr_d   = MCU_ADDR;
               dq_out_d = MCU_WE ? MCU_WDATA : dq_out_q;
               cnt_d    = MCU_WE ? 4'(WR_WAIT) : 4'(RD_WAIT);
               src_d    = 1'b1;
               ce_n_d   = 1'b0;
               oe_n_d   = MCU_WE;
               we_n_d   = ~MCU_WE;
               dq_oe_d  = MCU_WE;
            end
         end
         RD: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d   = RECOVER;
               ce_n_d    = 1'b1;
               oe_n_d    = 1'b1;
               valid_d   = ~src_q;
               ack_d     = src_q;
               snes_do_d = src_q ? snes_do_q : SRAM_DQ_IN;
               mcu_rd_d  = src_q ? SRAM_DQ_IN : mcu_rd_q;
            end
         end
         WR: begin
            // count 0 is the data hold cycle: WE_n released, bus still driven
            if (cnt_q == 4'd0) begin
               state_d = RECOVER;
               ce_n_d  = 1'b1;
               dq_oe_d = 1'b0;
               ack_d   = src_q;
            end else begin
               cnt_d  = cnt_q - 4'd1;
               we_n_d = cnt_q == 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         src_q     <= 1'b0;
         rd_pend_q <= 1'b0;
         wr_pend_q <= 1'b0;
         rd_prev_q <= 1'b1;
         wr_prev_q <= 1'b1;
         rd_addr_q <= 24'd0;
         wr_addr_q <= 24'd0;
         wr_data_q <= 8'd0;
         addr_q    <= 24'd0;
         dq_out_q  <= 8'd0;
         dq_oe_q   <= 1'b0;
         ce_n_q    <= 1'b1;
         oe_n_q    <= 1'b1;
         we_n_q    <= 1'b1;
         snes_do_q <= 8'd0;
         mcu_rd_q  <= 8'd0;
         valid_q   <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         src_q     <= src_d;
         rd_pend_q <= rd_pend_d;
         wr_pend_q <= wr_pend_d;
         rd_prev_q <= SNES_RD_n;
         wr_prev_q <= SNES_WR_n;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         addr_q    <= addr_d;
         dq_out_q  <= dq_out_d;
         dq_oe_q   <= dq_oe_d;
         ce_n_q    <= ce_n_d;
         oe_n_q    <= oe_n_d;
         we_n_q    <= we_n_d;
         snes_do_q <= snes_do_d;
         mcu_rd_q  <= mcu_rd_d;
         valid_q   <= valid_d;
         ack_q     <= ack_d;
      end
   end

   assign SNES_DATA_OUT   = snes_do_q;
   assign SNES_DATA_VALID = valid_q;
   assign MCU_RDATA       = mcu_rd_q;
   assign MCU_ACK         = ack_q;
   assign SRAM_ADDR       = addr_q;
   assign SRAM_DQ_OUT     = dq_out_q;
   assign SRAM_DQ_OE      = dq_oe_q;
   assign SRAM_CE_n       = ce_n_q;
   assign SRAM_OE_n       = oe_n_q;
   assign SRAM_WE_n       = we_n_q;
endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Downstream of the SNES address decoder: consumes its mapped 24-bit SRAM address and ROM/SaveRAM flags, runs timed cycles on the single external SRAM.
- Arbitrates SNES bus accesses (priority) against MCU byte requests (req/ack handshake) in the gaps between SNES cycles.
- Returns SNES read data with a valid strobe; ROM is write-protected, only SaveRAM accepts SNES writes.

Parameters:
RD_WAIT, 3, CLK cycles SRAM_OE_n held low before read data sampled (1..15)
WR_WAIT, 3, CLK cycles SRAM_WE_n held low per write (1..15)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
SNES_RD_n  in  1  SNES read strobe, already synchronised to CLK
SNES_WR_n  in  1  SNES write strobe, already synchronised to CLK
ROM_ADDR  in  24  mapped SRAM address from decoder
IS_ROM  in  1  current SNES address mapped as ROM
IS_SAVERAM  in  1  current SNES address mapped as SaveRAM
SNES_DATA_IN  in  8  SNES write data
SNES_DATA_OUT  out  8  SNES read data
SNES_DATA_VALID  out  1  one-cycle pulse, SNES_DATA_OUT updated
MCU_REQ  in  1  MCU request, level, held until ack
MCU_WE  in  1  1=write, 0=read; stable while MCU_REQ
MCU_ADDR  in  24  MCU byte address
MCU_WDATA  in  8  MCU write data
MCU_RDATA  out  8  MCU read data
MCU_ACK  out  1  one-cycle pulse, cycle complete
SRAM_ADDR  out  24  SRAM address
SRAM_DQ_IN  in  8  SRAM data in
SRAM_DQ_OUT  out  8  SRAM write data
SRAM_DQ_OE  out  1  drive SRAM data bus
SRAM_CE_n / SRAM_OE_n / SRAM_WE_n  out  1 each  SRAM strobes, active-low

Behaviour:
- Reset: state IDLE, SRAM_CE_n/OE_n/WE_n=1, SRAM_DQ_OE=0, SRAM_ADDR=0, SRAM_DQ_OUT=0, SNES_DATA_OUT=0, MCU_RDATA=0, SNES_DATA_VALID=0, MCU_ACK=0, pending flags cleared, previous-strobe registers=1. RST mid-cycle aborts immediately; no ACK/VALID issued.
- Events: SNES read = SNES_RD_n falling edge (prev 1, now 0) with IS_ROM|IS_SAVERAM; ROM_ADDR latched same cycle. SNES write = SNES_WR_n rising edge with IS_SAVERAM; ROM_ADDR and SNES_DATA_IN latched same cycle. Writes with IS_ROM=1 and IS_SAVERAM=0 ignored (write protect). Unmapped reads ignored.
- Each event sets a one-deep pending flag (rd_pend / wr_pend) with latched addr/data; a new SNES event overwrites the prior one only if not yet started.
- States: IDLE, RD, WR, RECOVER.
- IDLE priority: rd_pend > wr_pend > MCU_REQ. Entering RD/WR: SRAM_ADDR loaded, CE_n=0, counter=RD_WAIT/WR_WAIT, pending flag cleared, source tag (SNES/MCU) stored.
- RD: OE_n=0, DQ_OE=0; counter decrements each cycle; at 0: sample SRAM_DQ_IN into SNES_DATA_OUT (pulse SNES_DATA_VALID) or MCU_RDATA (pulse MCU_ACK); go RECOVER.
- WR: DQ_OE=1, SRAM_DQ_OUT=data, WE_n=0 while counter>0; at 0: WE_n=1, DQ_OE held 1 this cycle (hold time), MCU_ACK pulse if MCU; go RECOVER.
- RECOVER: 1 cycle all strobes high, DQ_OE=0; then IDLE.
- Latency SNES read: edge at cycle N -> VALID at N+RD_WAIT+1 when idle; worst case adds one full MCU cycle (RD/WR_WAIT+2).
- MCU_ACK asserted exactly once per request; MCU must deassert MCU_REQ the cycle after ACK; REQ still high in following IDLE = new request.
- Simultaneous SNES event and MCU_REQ in IDLE: SNES wins. SNES event during MCU cycle: pended, serviced next IDLE.
- Counter 4 bits; no address arithmetic performed; addresses passed unmodified.

Test Plan:
- Reset: RST=1 2 cycles with SNES_RD_n toggling -> all strobes 1, DQ_OE=0, no VALID/ACK.
- SNES ROM read: ROM_ADDR=0x500123, IS_ROM=1, RD_n falls at N, SRAM returns 0xA5 -> SRAM_ADDR=0x500123, OE_n low RD_WAIT cycles, VALID pulse at N+4 with SNES_DATA_OUT=0xA5.
- SaveRAM write: ROM_ADDR=0x7F0010, IS_SAVERAM=1, data 0x3C, WR_n rises -> WE_n low 3 cycles, SRAM_DQ_OUT=0x3C; same with IS_ROM=1 only -> no WE_n activity.
- MCU read/write: MCU_REQ write 0x000200<-0x11 then read 0x000200 with SRAM model -> two ACK pulses, MCU_RDATA=0x11.
- Collision: MCU_REQ and RD_n falling same cycle -> SNES cycle first, MCU ACK after RECOVER; RD_n falling mid-MCU write -> VALID immediately after that write's RECOVER+RD_WAIT+1.
- Reset mid-read (RST in RD) -> strobes high next cycle, no VALID, next read completes normally.
